// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer; flush inserts a NOP bubble.
// Latency 1 cycle; in_ready comes from registered state only. Optional stats: PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int                DATA_W  = 32,
    parameter int                PC_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   main_pc;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;
    logic              accept;
    logic              drain;

    assign in_ready  = (state != TWO) & ~rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_pc    = main_pc;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // MAIN always drives the outputs; SKID only absorbs the one extra beat
    // that arrives while downstream is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= NOP_VAL;
            main_pc   <= '0;
            skid_data <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            main_data <= NOP_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_pc   <= in_pc;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data <= in_data;
                        main_pc   <= in_pc;
                    end else if (accept) begin
                        skid_data <= in_data;
                        skid_pc   <= in_pc;
                        state     <= TWO;
                    end else if (drain) begin
                        main_data <= NOP_VAL;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_data <= skid_data;
                        main_pc   <= skid_pc;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0]     held;
    logic [1:0]     discard;
    logic [CNT_W:0] flush_sum;

    assign held      = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
    // An entry taken by downstream on the flush cycle is not a loss.
    assign discard   = held - {1'b0, drain};
    assign flush_sum = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, discard};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
